inc_sched: RTL
==============

# inc_sched

Round-robin burst scheduler that shares one modulo-n incrementer (16-bit count, enable input, clock, async active-low reset) among four requesters. Each requester asks for a burst of L increment steps. The scheduler grants one requester at a time and drives the incrementer's enable for exactly L un-paused cycles. It then pulses done and reports modulo wrap-arounds seen during the burst. It sits between the requesting engines and the incrementer and is the only driver of that enable.

## Interface
- N, 8: modulus of the controlled incrementer; used only for wrap detection (count == N-1 on an enabled step).
- LENW, 4: width of each burst-length field.
- clock  in  1  rising-edge clock, shared with the incrementer.
- reset  in  1  reset, asynchronous, active-low; clock clock.
- req  in  4  per-requester request level; bit i = requester i.
- len  in  4*LENW  burst lengths; field i = len[i*LENW +: LENW]; sampled only at grant.
- hold  in  1  pause; while 1, enable is forced to 0 and the burst does not advance.
- count  in  16  current incrementer output, for wrap detection.
- enable  out  1  drives the incrementer enable.
- grant  out  4  one-hot owner of the current burst; 0 when idle.
- done  out  1  one-cycle pulse when the granted burst completes.
- done_id  out  2  index of the finishing requester; valid when done=1.
- wrap  out  1  one-cycle pulse, registered, after an enabled step with count == N-1.
- busy  out  1  1 in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. All state and outputs are registered, except enable = (state==RUN) & ~hold & (remaining != 0).
- Reset: state=IDLE, grant=0, done=0, done_id=0, wrap=0, busy=0, remaining=0, rr pointer=3, so requester 0 has top priority first.
- IDLE → RUN when req != 0:
  - Winner is the first set bit searching ptr+1, ptr+2, … modulo 4.
  - grant is set to the winner's one-hot; remaining is loaded with len[winner]; ptr is set to the winner.
- IDLE, req == 0: stays in IDLE; all outputs 0.
- RUN:
  - Each cycle with enable=1, remaining decrements.
  - When remaining == 1 and enable=1, or remaining == 0 on entry (len=0), the next state is DONE.
  - hold cycles neither decrement nor count toward L.
- DONE:
  - done=1 and done_id=winner for exactly one cycle; grant stays asserted during DONE.
  - Next state is IDLE; grant clears.
- A granted burst is committed: dropping req mid-RUN does not abort it. A requester that keeps req high after done is re-eligible, but at lowest priority because of the rr pointer.
- len = 0: the requester is granted, gets zero enable cycles, and still receives a done pulse.
- wrap:
  - wrap <= enable & (count == N-1), evaluated every cycle regardless of state.
  - wrap is 0 whenever enable was 0 in the prior cycle.
- Reset asserted mid-burst aborts immediately and asynchronously:
  - grant, enable, busy and done go to 0 with no done pulse.
  - The rr pointer returns to 3.

## Timing
- Request latency: req sampled high at edge k in IDLE gives grant/busy high after edge k. enable is high in that same cycle (cycle k+1) if hold=0.
- Burst of L ≥ 1 with no hold: enable is high for cycles k+1 … k+L. done is high in cycle k+L+1, then IDLE in cycle k+L+2. The earliest next grant is after edge k+L+2.
- Request-to-request turnaround is 2 idle cycles (DONE + IDLE) between bursts.
- Each hold cycle during RUN extends the burst by one cycle. hold has no effect in IDLE or DONE.
- Simultaneous requests resolve in a single cycle; there is no combinational path from req to grant.
- Max L = 2^LENW − 1. remaining is LENW bits and never underflows.

## Test plan
- Single burst: after reset, req=0001, len0=3, hold=0, count starting at 0 (N=8). Required response:
  - grant=0001 and enable for 3 cycles; count → 3.
  - done with done_id=0 in the following cycle, then grant=0.
- Round-robin fairness: req=1111 held with all len=1. Required response:
  - Grants in order 0,1,2,3,0.
  - Each grant is separated by DONE+IDLE.
  - done_id sequence 0,1,2,3,0.
- Hold and wrap: req=0100, len2=10, count=5 at grant, hold high for 2 cycles mid-burst. Required response:
  - 10 enable cycles over 12 RUN cycles.
  - wrap pulses once, in the cycle after the enabled step at count=7.
  - Final count=(5+10)%8=7.
- Zero length: req=0010, len1=0. Required response:
  - grant=0010 for 2 cycles with no enable.
  - done=1 with done_id=1; count unchanged.
- Committed burst and re-arbitration: req0 granted with len=4, req0 dropped after 1 cycle, req3 raised meanwhile. Required response:
  - All 4 enables are issued and done_id=0.
  - The next grant is 1000.
- Reset mid-burst: reset pulsed low during RUN with remaining=5. Required response:
  - grant, enable and busy go to 0 immediately; no done pulse.
  - After release with req=1001, requester 0 is granted first.

Source files
------------

// File: rtl/inc_sched.sv
// inc_sched: round-robin burst scheduler sharing one modulo-N incrementer among
// four requesters. One burst of L enabled steps per grant, then a done pulse.
module inc_sched #(
    parameter int unsigned N    = 8,
    parameter int unsigned LENW = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          req,
    input  logic [4*LENW-1:0]   len,
    input  logic                hold,
    input  logic [15:0]         count,
    output logic                enable,
    output logic [3:0]          grant,
    output logic                done,
    output logic [1:0]          done_id,
    output logic                wrap,
    output logic                busy
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned CNTW = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNTW-1:0] WRAP_AT = CNTW'(N - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [LENW-1:0] r_rem;
    logic [LENW-1:0] w_rem_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [3:0]      r_grant;
    logic [3:0]      w_grant_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic [IDW-1:0]  r_done_id;
    logic [IDW-1:0]  w_done_id_nxt;
    logic            r_wrap;
    logic            w_wrap_nxt;
    logic            r_busy;
    logic            w_busy_nxt;

    logic            w_enable;
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_idx;

    // Incrementer enable: only while running, not paused, and steps remain
    assign w_enable = (r_state == S_RUN) & ~hold & (r_rem != '0);

    assign enable  = w_enable;
    assign grant   = r_grant;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign wrap    = r_wrap;
    assign busy    = r_busy;

    // Round-robin search: first set request after the previous winner
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = r_ptr + IDW'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_rem;
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = r_grant;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = '0;
        w_busy_nxt    = r_busy;
        w_wrap_nxt    = w_enable & (count == WRAP_AT);

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_RUN;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_rem_nxt   = len[int'(w_win)*LENW +: LENW];
                    w_ptr_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if ((r_rem == '0) || (w_enable && (r_rem == LENW'(1)))) begin
                    w_state_nxt   = S_DONE;
                    w_rem_nxt     = '0;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_ptr;
                end else if (w_enable) begin
                    w_rem_nxt = r_rem - LENW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_rem_nxt   = '0;
            end
        endcase
    end

    // State register; reset aborts any burst and restores requester 0 priority
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_ptr     <= IDW'(NREQ - 1);
            r_grant   <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_wrap    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rem     <= w_rem_nxt;
            r_ptr     <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
            r_wrap    <= w_wrap_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

endmodule
